// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the sequential ALU.
//   - opcode encodings (OP_ADD .. OP_MULU, OP_LAST marks the last legal code)
//   - FSM state encoding for the top-level control (ST_IDLE, ST_BUSY)
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_NEG  = 4'd2;
  localparam logic [3:0] OP_PASS = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_XOR  = 4'd6;
  localparam logic [3:0] OP_NOT  = 4'd7;
  localparam logic [3:0] OP_SHL  = 4'd8;
  localparam logic [3:0] OP_SHR  = 4'd9;
  localparam logic [3:0] OP_MULU = 4'd10;
  localparam logic [3:0] OP_LAST = OP_MULU;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/alu_seq_core.sv
// alu_seq_core: combinational single-cycle datapath for every op except MULU.
// Ports:
//   op    [3:0]  operation code (MULU and 11..15 fall into the illegal branch)
//   a, b  [W-1:0] operands; b also supplies the shift amount for SHL/SHR
//   res   [W-1:0] result
//   carry, ovf, zero, sign, err  flags derived from res and the op
module alu_seq_core
  import alu_pkg::*;
#(
  parameter int W = 4,
  localparam int SW = $clog2(W)
) (
  input  logic [3:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] res,
  output logic         carry,
  output logic         ovf,
  output logic         zero,
  output logic         sign,
  output logic         err
);

  localparam logic [W:0] W_LIM = (W+1)'(W);

  logic [W:0]    add_w;
  logic [W:0]    sub_w;
  logic [W:0]    shl_w;
  logic [W:0]    shr_w;
  logic [SW-1:0] shamt;
  logic          big_shift;

  // The whole of b decides whether the shift is out of range; only when it is
  // below W does the low SW-bit field give the actual amount.
  assign shamt     = b[SW-1:0];
  assign big_shift = ({1'b0, b} >= W_LIM);

  assign add_w = {1'b0, a} + {1'b0, b};
  assign sub_w = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);

  // One guard bit beside the operand catches the last bit shifted out:
  // bit W for a left shift, bit 0 for a right shift (0 when amount is 0).
  assign shl_w = {1'b0, a} << shamt;
  assign shr_w = {a, 1'b0} >> shamt;

  always_comb begin
    res   = '0;
    carry = 1'b0;
    ovf   = 1'b0;
    err   = 1'b0;
    case (op)
      OP_ADD: begin
        res   = add_w[W-1:0];
        carry = add_w[W];
        ovf   = (a[W-1] == b[W-1]) && (add_w[W-1] != a[W-1]);
      end
      OP_SUB: begin
        res   = sub_w[W-1:0];
        carry = sub_w[W];
        ovf   = (a[W-1] != b[W-1]) && (sub_w[W-1] != a[W-1]);
      end
      OP_NEG: begin
        res   = ~a + {{(W-1){1'b0}}, 1'b1};
        carry = (a == '0);
        ovf   = (a == {1'b1, {(W-1){1'b0}}});
      end
      OP_PASS: res = a;
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      OP_NOT:  res = ~a;
      OP_SHL: begin
        if (!big_shift) begin
          res   = shl_w[W-1:0];
          carry = shl_w[W];
        end
      end
      OP_SHR: begin
        if (!big_shift) begin
          res   = shr_w[W:1];
          carry = shr_w[0];
        end
      end
      default: err = 1'b1;
    endcase
  end

  assign zero = (res == '0);
  assign sign = res[W-1];

endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered W-bit ALU with an iterative shift-add unsigned multiply.
// Ports:
//   clk, reset (sync, active-low)
//   start, op[3:0], a[W-1:0], b[W-1:0]  request side; sampled only at accept
//   ready   1 while idle (an accept can happen this cycle)
//   done    one-cycle pulse after the edge that updated the result registers
//   r, r_hi result (r_hi = high half of a MULU product, else 0)
//   zero, carry, sign, ovf, err  flags, held until the next completion
//
// Handshake: a request is accepted on a rising edge where start=1 and
// ready=1; op/a/b are captured on that edge and may change afterwards. start
// while ready=0 is dropped, never queued. done rises for exactly one cycle per
// accepted request, in the cycle after the edge that wrote r/r_hi/flags.
module alu_seq
  import alu_pkg::*;
#(
  parameter int W = 4,
  localparam int SW = $clog2(W)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [3:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         ready,
  output logic         done,
  output logic [W-1:0] r,
  output logic [W-1:0] r_hi,
  output logic         zero,
  output logic         carry,
  output logic         sign,
  output logic         ovf,
  output logic         err
);

  localparam logic [SW-1:0] LAST_CNT = SW'(W-1);

  state_t state, state_next;
  logic   accept;
  logic   mul_go;
  logic   mul_last;

  logic [W-1:0]   core_res;
  logic           core_carry, core_ovf, core_zero, core_sign, core_err;

  logic [2*W-1:0] mcand;
  logic [2*W-1:0] acc;
  logic [2*W-1:0] acc_next;
  logic [W-1:0]   mplier;
  logic [SW-1:0]  count;

  alu_seq_core #(.W(W)) u_core (
    .op    (op),
    .a     (a),
    .b     (b),
    .res   (core_res),
    .carry (core_carry),
    .ovf   (core_ovf),
    .zero  (core_zero),
    .sign  (core_sign),
    .err   (core_err)
  );

  always_ff @(posedge clk) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    mul_go     = 1'b0;
    mul_last   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          accept = 1'b1;
          if (op == OP_MULU) begin
            mul_go     = 1'b1;
            state_next = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        if (count == LAST_CNT) begin
          mul_last   = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign ready = (state == ST_IDLE);

  // One partial product per BUSY edge; the final step's sum feeds the output
  // registers directly so the result lands on the W-th edge.
  assign acc_next = mplier[0] ? (acc + mcand) : acc;

  always_ff @(posedge clk) begin
    if (!reset) begin
      mcand  <= '0;
      acc    <= '0;
      mplier <= '0;
      count  <= '0;
    end else if (mul_go) begin
      mcand  <= {{W{1'b0}}, a};
      acc    <= '0;
      mplier <= b;
      count  <= '0;
    end else if (state == ST_BUSY) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      done  <= 1'b0;
      r     <= '0;
      r_hi  <= '0;
      zero  <= 1'b0;
      carry <= 1'b0;
      sign  <= 1'b0;
      ovf   <= 1'b0;
      err   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept && !mul_go) begin
        done  <= 1'b1;
        r     <= core_res;
        r_hi  <= '0;
        zero  <= core_zero;
        carry <= core_carry;
        sign  <= core_sign;
        ovf   <= core_ovf;
        err   <= core_err;
      end else if (mul_last) begin
        done  <= 1'b1;
        r     <= acc_next[W-1:0];
        r_hi  <= acc_next[2*W-1:W];
        zero  <= (acc_next == '0);
        carry <= (acc_next[2*W-1:W] != '0);
        sign  <= acc_next[2*W-1];
        ovf   <= 1'b0;
        err   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;
  import alu_pkg::*;

  localparam int    W = 4;
  localparam longint M = longint'(1) << W;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;
  logic start;
  logic [3:0]   op;
  logic [W-1:0] a, b;
  logic         ready, done, zero, carry, sign, ovf, err;
  logic [W-1:0] r, r_hi;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  alu_seq #(.W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .ready (ready),
    .done  (done),
    .r     (r),
    .r_hi  (r_hi),
    .zero  (zero),
    .carry (carry),
    .sign  (sign),
    .ovf   (ovf),
    .err   (err)
  );

  int n_vec;
  int n_err;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit     m_valid;
  longint m_busy, m_cnt, m_done, m_prod;
  longint m_r, m_hi, m_zero, m_carry, m_sign, m_ovf, m_err;

  function automatic longint sval(input longint v);
    return (v >= M/2) ? v - M : v;
  endfunction

  function automatic longint oor(input longint s);
    return ((s < -(M/2)) || (s > M/2 - 1)) ? 1 : 0;
  endfunction

  task automatic model_exec(input longint o, input longint x, input longint y);
    longint s;
    m_hi = 0; m_carry = 0; m_ovf = 0; m_err = 0;
    case (o)
      0: begin s = x + y; m_r = s % M; m_carry = (s >= M); m_ovf = oor(sval(x) + sval(y)); end
      1: begin s = x + (M - 1 - y) + 1; m_r = s % M; m_carry = (s >= M); m_ovf = oor(sval(x) - sval(y)); end
      2: begin m_r = (M - x) % M; m_carry = (x == 0); m_ovf = oor(-sval(x)); end
      3: m_r = x;
      4: m_r = x & y;
      5: m_r = x | y;
      6: m_r = x ^ y;
      7: m_r = M - 1 - x;
      8: begin
        if (y == 0) m_r = x;
        else if (y >= W) m_r = 0;
        else begin m_r = (x << y) % M; m_carry = (x >> (W - y)) & 1; end
      end
      9: begin
        if (y == 0) m_r = x;
        else if (y >= W) m_r = 0;
        else begin m_r = x >> y; m_carry = (x >> (y - 1)) & 1; end
      end
      default: begin m_r = 0; m_err = 1; end
    endcase
    m_zero = (m_r == 0);
    m_sign = (m_r >> (W - 1)) & 1;
  endtask

  always @(posedge clk) begin
    m_valid = 1'b1;
    m_done  = 0;
    if (!reset) begin
      m_busy = 0; m_cnt = 0; m_r = 0; m_hi = 0;
      m_zero = 0; m_carry = 0; m_sign = 0; m_ovf = 0; m_err = 0;
    end else if (m_busy != 0) begin
      m_cnt--;
      if (m_cnt == 0) begin
        m_busy  = 0;
        m_done  = 1;
        m_r     = m_prod % M;
        m_hi    = m_prod / M;
        m_zero  = (m_prod == 0);
        m_carry = (m_hi != 0);
        m_sign  = (m_hi >> (W - 1)) & 1;
        m_ovf   = 0;
        m_err   = 0;
      end
    end else if (start) begin
      if (op == OP_MULU) begin
        m_busy = 1;
        m_cnt  = W;
        m_prod = longint'(a) * longint'(b);
      end else begin
        model_exec(longint'(op), longint'(a), longint'(b));
        m_done = 1;
      end
    end
  end

  // ---------------- scoreboard compare, every cycle ----------------
  always @(negedge clk) begin
    if (m_valid) begin
      check("ready", 64'(ready), 64'(m_busy == 0));
      check("done",  64'(done),  64'(m_done));
      check("r",     64'(r),     64'(m_r));
      check("r_hi",  64'(r_hi),  64'(m_hi));
      check("zero",  64'(zero),  64'(m_zero));
      check("carry", 64'(carry), 64'(m_carry));
      check("sign",  64'(sign),  64'(m_sign));
      check("ovf",   64'(ovf),   64'(m_ovf));
      check("err",   64'(err),   64'(m_err));
    end
  end

  // ---------------- driver ----------------
  task automatic step(input logic s, input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk);
    start = s; op = o; a = x; b = y;
  endtask

  task automatic idle();
    step(1'b0, OP_PASS, '0, '0);
  endtask

  typedef struct {
    logic [3:0]   o;
    logic [W-1:0] x;
    logic [W-1:0] y;
  } vec_t;

  vec_t extra[12];

  initial begin
    extra[0]  = '{OP_ADD,  4'hF, 4'h1};
    extra[1]  = '{OP_SUB,  4'h3, 4'h5};
    extra[2]  = '{OP_SUB,  4'h8, 4'h1};
    extra[3]  = '{OP_PASS, 4'hA, 4'h0};
    extra[4]  = '{OP_AND,  4'hC, 4'hA};
    extra[5]  = '{OP_OR,   4'hC, 4'hA};
    extra[6]  = '{OP_NOT,  4'h5, 4'h0};
    extra[7]  = '{OP_SHL,  4'hB, 4'h0};
    extra[8]  = '{OP_SHL,  4'h3, 4'h3};
    extra[9]  = '{OP_SHR,  4'hB, 4'h2};
    extra[10] = '{OP_SHR,  4'h8, 4'h3};
    extra[11] = '{OP_NEG,  4'h0, 4'h0};

    n_vec = 0; n_err = 0;
    reset = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    check("rst_ready", 64'(ready), 64'd1);
    check("rst_done",  64'(done),  64'd0);
    check("rst_r",     64'(r),     64'd0);
    check("rst_err",   64'(err),   64'd0);
    reset = 1'b1;
    idle();

    // ADD 0111 + 0001
    step(1'b1, OP_ADD, 4'b0111, 4'b0001);
    idle();
    check("add_done", 64'(done), 64'd1);
    check("add_r", 64'(r), 64'b1000);
    check("add_sign", 64'(sign), 64'd1);
    check("add_ovf", 64'(ovf), 64'd1);
    check("add_carry", 64'(carry), 64'd0);
    check("add_zero", 64'(zero), 64'd0);
    check("add_err", 64'(err), 64'd0);
    idle();
    check("add_done_drop", 64'(done), 64'd0);
    check("add_r_hold", 64'(r), 64'b1000);

    // SUB 0011 - 0011
    step(1'b1, OP_SUB, 4'b0011, 4'b0011);
    idle();
    check("sub_r", 64'(r), 64'd0);
    check("sub_zero", 64'(zero), 64'd1);
    check("sub_carry", 64'(carry), 64'd1);
    check("sub_ovf", 64'(ovf), 64'd0);

    // NEG 1000
    step(1'b1, OP_NEG, 4'b1000, 4'b0000);
    idle();
    check("neg_r", 64'(r), 64'b1000);
    check("neg_ovf", 64'(ovf), 64'd1);
    check("neg_carry", 64'(carry), 64'd0);

    // MULU 1111 * 1111, with an ignored ADD request while busy
    step(1'b1, OP_MULU, 4'b1111, 4'b1111);
    for (int i = 0; i < W; i++) begin
      step(i == 1, OP_ADD, 4'b0001, 4'b0001);
      check("mul_ready_low", 64'(ready), 64'd0);
      check("mul_no_done", 64'(done), 64'd0);
    end
    idle();
    check("mul_done", 64'(done), 64'd1);
    check("mul_ready", 64'(ready), 64'd1);
    check("mul_r_hi", 64'(r_hi), 64'b1110);
    check("mul_r", 64'(r), 64'b0001);
    check("mul_carry", 64'(carry), 64'd1);
    check("mul_sign", 64'(sign), 64'd1);
    idle();
    check("mul_no_extra_done", 64'(done), 64'd0);

    // back-to-back ADD then XOR
    step(1'b1, OP_ADD, 4'b0001, 4'b0001);
    step(1'b1, OP_XOR, 4'b1010, 4'b0110);
    check("b2b_done1", 64'(done), 64'd1);
    check("b2b_r1", 64'(r), 64'b0010);
    idle();
    check("b2b_done2", 64'(done), 64'd1);
    check("b2b_r2", 64'(r), 64'b1100);

    // SHL 1001 by 1
    step(1'b1, OP_SHL, 4'b1001, 4'b0001);
    idle();
    check("shl_r", 64'(r), 64'b0010);
    check("shl_carry", 64'(carry), 64'd1);

    // SHR 0001 by 4 (amount >= W)
    step(1'b1, OP_SHR, 4'b0001, 4'b0100);
    idle();
    check("shr_r", 64'(r), 64'd0);
    check("shr_carry", 64'(carry), 64'd0);
    check("shr_zero", 64'(zero), 64'd1);

    // illegal opcode
    step(1'b1, 4'b1111, 4'b0101, 4'b0011);
    idle();
    check("ill_err", 64'(err), 64'd1);
    check("ill_r", 64'(r), 64'd0);
    check("ill_zero", 64'(zero), 64'd1);

    // extra directed vectors, checked by the model
    foreach (extra[i]) begin
      step(1'b1, extra[i].o, extra[i].x, extra[i].y);
      idle();
    end
    check("ill_err_cleared", 64'(err), 64'd0);

    // MULU with a zero operand
    step(1'b1, OP_MULU, 4'b0000, 4'b1011);
    repeat (W + 1) idle();
    check("mul0_zero", 64'(zero), 64'd1);

    // reset on the 2nd BUSY cycle of a MULU
    step(1'b1, OP_MULU, 4'b0011, 4'b0101);
    idle();
    @(negedge clk);
    start = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("abort_ready", 64'(ready), 64'd1);
    check("abort_r", 64'(r), 64'd0);
    check("abort_r_hi", 64'(r_hi), 64'd0);
    check("abort_flags", 64'({zero, carry, sign, ovf, err}), 64'd0);
    for (int i = 0; i < 10; i++) begin
      idle();
      check("abort_no_done", 64'(done), 64'd0);
    end

    idle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor of the team's 4-bit combinational ALU.
- Generalised to W bits. Adds logic, shift and an iterative unsigned multiply, plus a signed-overflow flag.
- Uses a start/ready/done handshake so the CPU datapath control unit can issue one operation per cycle, or stall on a multi-cycle multiply.
- Results and flags are held in registers until the next completion.

Parameters:
- W, 4, operand/result width in bits (legal range 2..32).
- SW, $clog2(W), width of the shift-amount field taken from b (derived; never overridden).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset.
- start  input  1  request; accepted on an edge where start=1 and ready=1.
- op  input  4  operation code, sampled only at accept.
- a  input  W  operand A, sampled only at accept.
- b  input  W  operand B, sampled only at accept.
- ready  output  1  1 = IDLE, can accept this cycle.
- done  output  1  one-cycle pulse: r/r_hi/flags updated this cycle.
- r  output  W  result (low half for MULU).
- r_hi  output  W  high half of MULU product; 0 for all other ops.
- zero  output  1  result == 0 (MULU: the full 2W product == 0).
- carry  output  1  carry/no-borrow/shift-out; see op list.
- sign  output  1  MSB of result (MULU: r_hi[W-1]).
- ovf  output  1  signed overflow.
- err  output  1  illegal opcode completed.

Behaviour:
- Reset (reset=0 at an edge):
  - state=IDLE, ready=1; done, err, r, r_hi, zero, carry, sign, ovf all 0.
  - Reset wins over start.
  - Reset during BUSY aborts the multiply; no done is produced afterwards.
- Op codes (carry=0 and ovf=0 unless stated):
  - 0 ADD: r=a+b; carry=cout; ovf=signed overflow.
  - 1 SUB: r=a+~b+1; carry=cout (1 = no borrow); ovf=signed overflow.
  - 2 NEG: r=~a+1; carry=(a==0); ovf=(a==100..0).
  - 3 PASS: r=a.
  - 4 AND, 5 OR, 6 XOR: bitwise a,b.
  - 7 NOT: r=~a.
  - 8 SHL: r=a<<b[SW-1:0]; carry=last bit shifted out. Amount 0 gives carry=0; amount >= W gives r=0, carry=0.
  - 9 SHR: logical right shift; carry and amount rules as SHL.
  - 10 MULU: {r_hi,r}=a*b unsigned; carry=(r_hi!=0).
  - 11..15 illegal: r=0, r_hi=0, zero=1, err=1, other flags 0.
- err is 0 on every legal completion.
- FSM states: IDLE and BUSY.
- Single-cycle ops (all except MULU):
  - Accept at edge k writes result and flags on that edge; done=1 in the cycle after edge k.
  - State stays IDLE and ready stays 1, so back-to-back accepts give done on consecutive cycles.
- MULU:
  - Accept at edge k: latch a and b, clear the accumulator, count=0, state=BUSY, ready=0.
  - Edges k+1..k+W: one shift-add step each.
  - Edge k+W: write r, r_hi and flags; state=IDLE, ready=1, done=1 in the following cycle.
  - Latency from start to done is W+1 cycles.
- start while BUSY is ignored: no queueing, no effect on the multiply.
- op, a and b may change freely after accept.
- done is never asserted in two consecutive cycles for the same op.
- Outputs hold their last values between completions; they are not cleared when done drops.
- Flags are computed from the W-bit result except where MULU rules apply above.

Decomposition:
- Package alu_pkg holds:
  - opcode localparams (OP_ADD..OP_MULU, with OP_LAST=10);
  - state encoding (ST_IDLE, ST_BUSY).
- Sub-module alu_seq_core: purely combinational single-cycle datapath (ops 0..9 plus the illegal default), outputs result and flags.
- Top level holds the FSM, the multiply iteration registers and the output registers.

Test Plan (W=4):
- ADD a=0111 b=0001 -> 1 cycle later: done=1, r=1000, sign=1, ovf=1, carry=0, zero=0, err=0.
- SUB a=0011 b=0011 -> r=0000, zero=1, carry=1, ovf=0.
- NEG a=1000 -> r=1000, ovf=1, carry=0.
- MULU a=1111 b=1111:
  - ready=0 for exactly 4 cycles after accept; done 5 cycles after start; r_hi=1110, r=0001, carry=1, sign=1.
  - A start pulse with op=ADD during BUSY produces no extra done.
- Back-to-back: ADD 0001+0001, then XOR 1010^0110 on the next cycle -> done high 2 consecutive cycles, r=0010 then r=1100.
- SHL a=1001 b=0001 -> r=0010, carry=1.
- SHR a=0001 b=0100 (amount >= W) -> r=0000, carry=0, zero=1.
- Illegal op=1111 -> err=1, r=0, zero=1.
- reset=0 on the 2nd BUSY cycle of a MULU -> next cycle ready=1, all outputs 0, and no done for 10 cycles without start.
